// File: rtl/s2_pkg.sv
// s2_pkg: shared state encoding and default width for the s2 serial transmitter.
package s2_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/s2_bitcnt.sv
// s2_bitcnt: loadable down-counter with a zero flag, counting remaining bits of a word.
module s2_bitcnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : dec_i ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/s2_seq_tx.sv
// s2_seq_tx: captures a pattern word and shifts len+1 bits out serially, MSB- or LSB-first,
// with registered valid/busy/done handshake outputs.
module s2_seq_tx
  import s2_pkg::*;
#(
  parameter int   WIDTH      = WIDTH_DEF,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         pat,
  input  logic [$clog2(WIDTH)-1:0] len,
  input  logic                     msb_first,
  output logic                     outp,
  output logic                     out_vld,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state
);
  localparam int LW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             msb_q, msb_d, outp_q, outp_d, vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic             load, dec, zero;
  s2_bitcnt #(.W(LW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load_i(load),
    .dec_i (dec),
    .val_i (len),
    .zero_o(zero)
  );
  // MSB-first words are left-aligned so pat[len] sits at the top and upper bits shift out unseen.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    msb_d   = msb_q;
    vld_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_SEND;
        msb_d   = msb_first;
        sr_d    = msb_first ? pat << (LW'(WIDTH - 1) - len) : pat;
        load    = 1'b1;
        vld_d   = 1'b1;
        busy_d  = 1'b1;
      end
      S_SEND: if (zero) begin
        state_d = S_DONE;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end else begin
        sr_d    = msb_q ? sr_q << 1 : sr_q >> 1;
        dec     = 1'b1;
        vld_d   = 1'b1;
        busy_d  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    outp_d = vld_d ? (msb_d ? sr_d[WIDTH-1] : sr_d[0]) : IDLE_LEVEL;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      msb_q   <= 1'b0;
      outp_q  <= IDLE_LEVEL;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      msb_q   <= msb_d;
      outp_q  <= outp_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign outp    = outp_q;
  assign out_vld = vld_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state   = state_q;
endmodule

// File: tb/tb_s2_seq_tx.sv
// tb_s2_seq_tx: directed bench for s2_seq_tx with hand-computed bit streams.
module tb_s2_seq_tx;
  logic       clk = 1'b0;
  logic       rst, start, msb_first;
  logic [7:0] pat;
  logic [2:0] len;
  logic       outp, out_vld, busy, done;
  logic [1:0] state;
  int checks = 0, fails = 0;

  s2_seq_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .len(len), .msb_first(msb_first),
    .outp(outp), .out_vld(out_vld), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] p, input logic [2:0] l, input logic m);
    pat = p; len = l; msb_first = m; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; pat = '0; len = '0; msb_first = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({outp, out_vld, busy, done, state} !== 6'b0) begin
      fails++; $display("FAIL reset_async: got %b required %b", {outp, out_vld, busy, done, state}, 6'b0);
    end
    step(); step();
    #3 rst = 1'b1;
    step();
    checks++;
    if ({outp, out_vld, busy, done, state} !== 6'b0) begin
      fails++; $display("FAIL reset_release: got %b required %b", {outp, out_vld, busy, done, state}, 6'b0);
    end
  endtask

  task automatic test_basic_msb;
    bit b[7] = '{1, 0, 1, 0, 1, 1, 0};
    launch(8'h56, 3'd6, 1'b1);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({outp, out_vld, busy, done, state} !== {b[k], 3'b110, 2'd1}) begin
        fails++; $display("FAIL msb_bit%0d: got %b required %b", k, {outp, out_vld, busy, done, state}, {b[k], 3'b110, 2'd1});
      end
      step();
    end
    checks++;
    if ({outp, out_vld, busy, done, state} !== 6'b0011_10) begin
      fails++; $display("FAIL msb_done: got %b required %b", {outp, out_vld, busy, done, state}, 6'b0011_10);
    end
    step();
    checks++;
    if ({outp, out_vld, busy, done, state} !== 6'b0) begin
      fails++; $display("FAIL msb_idle: got %b required %b", {outp, out_vld, busy, done, state}, 6'b0);
    end
  endtask

  task automatic test_lsb;
    bit b[7] = '{0, 1, 1, 0, 1, 0, 1};
    launch(8'h56, 3'd6, 1'b0);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({outp, out_vld, busy, done, state} !== {b[k], 3'b110, 2'd1}) begin
        fails++; $display("FAIL lsb_bit%0d: got %b required %b", k, {outp, out_vld, busy, done, state}, {b[k], 3'b110, 2'd1});
      end
      step();
    end
    checks++;
    if ({outp, out_vld, busy, done, state} !== 6'b0011_10) begin
      fails++; $display("FAIL lsb_done: got %b required %b", {outp, out_vld, busy, done, state}, 6'b0011_10);
    end
    step();
    checks++;
    if ({outp, out_vld, busy, done, state} !== 6'b0) begin
      fails++; $display("FAIL lsb_idle: got %b required %b", {outp, out_vld, busy, done, state}, 6'b0);
    end
  endtask

  task automatic test_single_bit;
    logic [7:0] pats[3] = '{8'hFF, 8'hFE, 8'hFE};
    bit         msbs[3] = '{1, 1, 0};
    bit         exp[3]  = '{1, 0, 0};
    for (int t = 0; t < 3; t++) begin
      launch(pats[t], 3'd0, msbs[t]);
      checks++;
      if ({outp, out_vld, busy, done, state} !== {exp[t], 3'b110, 2'd1}) begin
        fails++; $display("FAIL single%0d_bit: got %b required %b", t, {outp, out_vld, busy, done, state}, {exp[t], 3'b110, 2'd1});
      end
      step();
      checks++;
      if ({outp, out_vld, busy, done, state} !== 6'b0011_10) begin
        fails++; $display("FAIL single%0d_done: got %b required %b", t, {outp, out_vld, busy, done, state}, 6'b0011_10);
      end
      step();
      checks++;
      if ({outp, out_vld, busy, done, state} !== 6'b0) begin
        fails++; $display("FAIL single%0d_idle: got %b required %b", t, {outp, out_vld, busy, done, state}, 6'b0);
      end
    end
  endtask

  task automatic test_ignore;
    bit b[7] = '{1, 0, 1, 0, 1, 1, 0};
    int dcount = 0;
    launch(8'h56, 3'd6, 1'b1);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({outp, out_vld, busy, done} !== {b[k], 3'b110}) begin
        fails++; $display("FAIL ignore_bit%0d: got %b required %b", k, {outp, out_vld, busy, done}, {b[k], 3'b110});
      end
      start = (k % 2 == 0); pat = ~pat; len = 3'(k); msb_first = ~msb_first;
      step();
    end
    checks++;
    if ({out_vld, busy, done, state} !== 5'b011_10) begin
      fails++; $display("FAIL ignore_done: got %b required %b", {out_vld, busy, done, state}, 5'b011_10);
    end
    dcount += int'(done);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dcount += int'(done);
      checks++;
      if ({out_vld, busy, done, state} !== 5'b0) begin
        fails++; $display("FAIL ignore_after%0d: got %b required %b", k, {out_vld, busy, done, state}, 5'b0);
      end
      step();
    end
    checks++;
    if (dcount !== 1) begin
      fails++; $display("FAIL ignore_done_count: got %0d required 1", dcount);
    end
  endtask

  task automatic test_back_to_back;
    bit b1[4] = '{0, 1, 0, 1};
    bit b2[3] = '{0, 0, 1};
    int dcount = 0;
    pat = 8'hA5; len = 3'd3; msb_first = 1'b1; start = 1'b1;
    step();
    pat = 8'h3C; len = 3'd2; msb_first = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({outp, out_vld, done} !== {b1[k], 2'b10}) begin
        fails++; $display("FAIL b2b_w1_bit%0d: got %b required %b", k, {outp, out_vld, done}, {b1[k], 2'b10});
      end
      step();
    end
    dcount += int'(done);
    checks++;
    if ({out_vld, busy, done, state} !== 5'b011_10) begin
      fails++; $display("FAIL b2b_w1_done: got %b required %b", {out_vld, busy, done, state}, 5'b011_10);
    end
    step();
    checks++;
    if ({out_vld, busy, done, state} !== 5'b0) begin
      fails++; $display("FAIL b2b_gap: got %b required %b", {out_vld, busy, done, state}, 5'b0);
    end
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({outp, out_vld, done} !== {b2[k], 2'b10}) begin
        fails++; $display("FAIL b2b_w2_bit%0d: got %b required %b", k, {outp, out_vld, done}, {b2[k], 2'b10});
      end
      step();
    end
    dcount += int'(done);
    step();
    checks++;
    if ({out_vld, busy, done, state} !== 5'b0) begin
      fails++; $display("FAIL b2b_end: got %b required %b", {out_vld, busy, done, state}, 5'b0);
    end
    checks++;
    if (dcount !== 2) begin
      fails++; $display("FAIL b2b_done_count: got %0d required 2", dcount);
    end
  endtask

  task automatic test_reset_mid;
    bit b[4] = '{1, 1, 0, 1};
    int dcount = 0;
    launch(8'h56, 3'd6, 1'b1);
    step(); step();
    checks++;
    if ({outp, out_vld, busy} !== 3'b111) begin
      fails++; $display("FAIL rmid_third_bit: got %b required %b", {outp, out_vld, busy}, 3'b111);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({outp, out_vld, busy, done, state} !== 6'b0) begin
      fails++; $display("FAIL rmid_async: got %b required %b", {outp, out_vld, busy, done, state}, 6'b0);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      dcount += int'(done);
    end
    #3 rst = 1'b1;
    step();
    dcount += int'(done);
    checks++;
    if ({outp, out_vld, busy, done, state} !== 6'b0 || dcount !== 0) begin
      fails++; $display("FAIL rmid_no_done: got %b dones=%0d required %b dones=0", {outp, out_vld, busy, done, state}, dcount, 6'b0);
    end
    launch(8'h0B, 3'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({outp, out_vld, busy, done} !== {b[k], 3'b110}) begin
        fails++; $display("FAIL rmid_clean_bit%0d: got %b required %b", k, {outp, out_vld, busy, done}, {b[k], 3'b110});
      end
      step();
    end
    checks++;
    if ({out_vld, busy, done, state} !== 5'b011_10) begin
      fails++; $display("FAIL rmid_clean_done: got %b required %b", {out_vld, busy, done, state}, 5'b011_10);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_msb();
    test_lsb();
    test_single_bit();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
